multicycle_ctrl: RTL

Main control state machine for the multi-cycle processor. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. In each state it drives every datapath mux select (PC source, address source, ALU operand A/B, write-back source, destination register), the register and memory enables, and the ALU operation class. It sits beside the datapath and stalls on a memory-ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_ctrl_decode.sv | 79 +++++++
 rtl/multicycle_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Encodings shared by the multicycle controller and its datapath.
// MULTICYCLE_CTRL_ADDI_EN adds the ADDI opcode and its ADDIWB write-back state.
package multicycle_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC,
        ST_ALUWB,
        ST_BRANCH,
        ST_JUMP
`ifdef MULTICYCLE_CTRL_ADDI_EN
        , ST_ADDIWB
`endif
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        pc_src_e    pc_src;
        alu_op_e    alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decode of the controller state, qualified by mem_ready and zero.
// MULTICYCLE_CTRL_ADDI_EN adds the ADDIWB decode.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    logic pc_write;
    logic pc_write_cond;

    always_comb begin
        ctrl          = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                pc_write       = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                pc_write_cond   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                pc_write        = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            ST_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
        ctrl.pc_en = pc_write | (pc_write_cond & zero);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor control FSM: state register, next-state logic, sticky illegal flag.
// MULTICYCLE_CTRL_ADDI_EN enables the ADDI opcode (MEMADR -> ADDIWB).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic [1:0]      alu_op,
    output logic            illegal,
    output logic            instr_done
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ST_MEMADR;
`endif
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                if (op == OP_LW)      state_d = ST_MEMRD;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                else if (op == OP_ADDI) state_d = ST_ADDIWB;
`endif
                else                  state_d = ST_MEMWR;
            end
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl_dec)
    );

    // The decoder is combinational on mem_ready/zero, so gate it to keep reset quiet.
    always_comb begin
        if (reset) ctrl_out = '0;
        else       ctrl_out = ctrl_dec;
    end

    assign pc_en      = ctrl_out.pc_en;
    assign i_or_d     = ctrl_out.i_or_d;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign ir_write   = ctrl_out.ir_write;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign reg_write  = ctrl_out.reg_write;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign pc_src     = ctrl_out.pc_src;
    assign alu_op     = ctrl_out.alu_op;
    assign instr_done = ctrl_out.instr_done;
    assign illegal    = illegal_q & ~reset;

endmodule
